// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input,
// counted in enabled samples (clk_en_i), and flags a pin stuck high or low.
//
// Ports:
//   clk_i         system clock, rising edge
//   rstn_i        asynchronous active-low reset
//   clk_en_i      sample enable; state advances only on enabled edges
//   PWM_pin_i     asynchronous PWM waveform
//   timeout_i     stuck-detect limit in enabled samples (0 = disabled)
//   high_cnt_o    last published high time
//   period_cnt_o  last published period
//   valid_STRB_o  one-cycle pulse following each publish
//   stuck_high_o  pin held high for timeout_i samples
//   stuck_low_o   pin held low (or never toggled) for timeout_i samples
module pwm_capture #(
  parameter int CNT_BITWIDTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clk_en_i,
  input  logic                    PWM_pin_i,
  input  logic [CNT_BITWIDTH-1:0] timeout_i,
  output logic [CNT_BITWIDTH-1:0] high_cnt_o,
  output logic [CNT_BITWIDTH-1:0] period_cnt_o,
  output logic                    valid_STRB_o,
  output logic                    stuck_high_o,
  output logic                    stuck_low_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    prev_q;
  logic                    sync_out, rise, fall, timeout_hit;
  logic [CNT_BITWIDTH-1:0] cnt_q, high_reg_q;

  logic                    pub, latch_high, set_sh, set_sl, clr_sh, clr_sl;
  logic [CNT_BITWIDTH-1:0] pub_high, pub_period;

  // Synchronizer and history flop reset high: a pin already high at release
  // gives no rise, a pin low gives a fall that IDLE ignores.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else if (clk_en_i) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PWM_pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;
  // Equality only: a limit lowered below the running count never fires.
  assign timeout_hit = (timeout_i != '0) && (cnt_q == timeout_i) && !rise && !fall;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else if (clk_en_i) state_q <= state_d;
  end

  // Outside STUCK, the synchronized level decides which stuck flag a timeout
  // raises: HIGH always has sync_out=1, LOW always 0, IDLE may be either.
  always_comb begin
    state_d    = state_q;
    pub        = 1'b0;
    pub_high   = '0;
    pub_period = '0;
    latch_high = 1'b0;
    set_sh     = 1'b0;
    set_sl     = 1'b0;
    clr_sh     = 1'b0;
    clr_sl     = 1'b0;
    case (state_q)
      STUCK: begin
        if (rise) begin
          clr_sh  = 1'b1;
          clr_sl  = 1'b1;
          state_d = HIGH;
        end else if (fall) begin
          clr_sh  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        if (state_q == IDLE && rise) begin
          state_d = HIGH;
        end else if (state_q == HIGH && fall) begin
          latch_high = 1'b1;
          state_d    = LOW;
        end else if (state_q == LOW && rise) begin
          pub        = 1'b1;
          pub_high   = high_reg_q;
          pub_period = cnt_q;
          state_d    = HIGH;
        end else if (timeout_hit) begin
          pub        = 1'b1;
          pub_period = timeout_i;
          state_d    = STUCK;
          if (sync_out) begin
            pub_high = timeout_i;
            set_sh   = 1'b1;
          end else begin
            set_sl   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q        <= '0;
      high_reg_q   <= '0;
      high_cnt_o   <= '0;
      period_cnt_o <= '0;
      valid_STRB_o <= 1'b0;
      stuck_high_o <= 1'b0;
      stuck_low_o  <= 1'b0;
    end else begin
      // Strobe is updated every clock so it drops after one cycle even when
      // the following cycle is not enabled.
      valid_STRB_o <= clk_en_i & pub;
      if (clk_en_i) begin
        if (rise) cnt_q <= CNT_BITWIDTH'(1);
        else if (cnt_q != '1) cnt_q <= cnt_q + CNT_BITWIDTH'(1);
        if (latch_high) high_reg_q <= cnt_q;
        if (pub) begin
          high_cnt_o   <= pub_high;
          period_cnt_o <= pub_period;
        end
        if (set_sh) begin
          stuck_high_o <= 1'b1;
          stuck_low_o  <= 1'b0;
        end else if (set_sl) begin
          stuck_low_o  <= 1'b1;
          stuck_high_o <= 1'b0;
        end else begin
          if (clr_sh) stuck_high_o <= 1'b0;
          if (clr_sl) stuck_low_o  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: default instance (8-bit counts) plus a
// 5-bit instance for saturation, both fed the same pin waveform.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b1;
  logic       pin = 1'b0;
  logic [7:0] timeout = '0;
  logic [4:0] timeout5 = '0;
  logic [7:0] high_cnt, period_cnt;
  logic [4:0] high5, period5;
  logic       valid, stuck_h, stuck_l;
  logic       valid5, stuck_h5, stuck_l5;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0, long_cnt = 0, strobe5_cnt = 0;
  logic valid_prev = 1'b0;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_BITWIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(en), .PWM_pin_i(pin),
    .timeout_i(timeout), .high_cnt_o(high_cnt), .period_cnt_o(period_cnt),
    .valid_STRB_o(valid), .stuck_high_o(stuck_h), .stuck_low_o(stuck_l)
  );

  pwm_capture #(.CNT_BITWIDTH(5), .SYNC_STAGES(2)) dut5 (
    .clk_i(clk), .rstn_i(rstn), .clk_en_i(en), .PWM_pin_i(pin),
    .timeout_i(timeout5), .high_cnt_o(high5), .period_cnt_o(period5),
    .valid_STRB_o(valid5), .stuck_high_o(stuck_h5), .stuck_low_o(stuck_l5)
  );

  // Strobe monitor: counts pulses and pulses wider than one clock.
  always @(negedge clk) begin
    if (valid) strobe_cnt = strobe_cnt + 1;
    if (valid && valid_prev) long_cnt = long_cnt + 1;
    valid_prev = valid;
    if (valid5) strobe5_cnt = strobe5_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // n enabled samples at level lvl; half inserts a disabled clock before each.
  task automatic drive(input logic lvl, input int n, input bit half);
    for (int i = 0; i < n; i++) begin
      pin = lvl;
      if (half) begin
        en = 1'b0;
        step(1);
      end
      en = 1'b1;
      step(1);
    end
  endtask

  task automatic do_reset(input logic lvl);
    pin = lvl;
    en = 1'b1;
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    pin = 1'b0;
    rstn = 1'b0;
    step(2);
    checks++; if (high_cnt !== 8'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", high_cnt); end
    checks++; if (period_cnt !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", period_cnt); end
    checks++; if ({valid, stuck_h, stuck_l} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {valid, stuck_h, stuck_l}); end
  endtask

  task automatic test_basic;
    int base;
    timeout = '0;
    do_reset(1'b0);
    base = strobe_cnt;
    drive(1'b0, 10, 1'b0);
    repeat (3) begin
      drive(1'b1, 5, 1'b0);
      drive(1'b0, 15, 1'b0);
    end
    // Rise enters sync flop 0 at sample k; strobe is visible after sample k+2.
    pin = 1'b1;
    step(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_k: got %b expected 0", valid); end
    step(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_k1: got %b expected 0", valid); end
    step(1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL lat_k2: got %b expected 1", valid); end
    checks++; if (high_cnt !== 8'd5) begin errors++; $display("FAIL basic_high: got %0d expected 5", high_cnt); end
    checks++; if (period_cnt !== 8'd20) begin errors++; $display("FAIL basic_period: got %0d expected 20", period_cnt); end
    step(1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL lat_drop: got %b expected 0", valid); end
    drive(1'b1, 1, 1'b0);
    checks++; if (strobe_cnt - base !== 3) begin errors++; $display("FAIL basic_strobes: got %0d expected 3", strobe_cnt - base); end
  endtask

  task automatic test_half_rate;
    int base_s, base_l;
    timeout = '0;
    do_reset(1'b0);
    base_s = strobe_cnt;
    base_l = long_cnt;
    drive(1'b0, 10, 1'b1);
    repeat (3) begin
      drive(1'b1, 5, 1'b1);
      drive(1'b0, 15, 1'b1);
    end
    drive(1'b1, 5, 1'b1);
    step(2);
    checks++; if (high_cnt !== 8'd5) begin errors++; $display("FAIL half_high: got %0d expected 5", high_cnt); end
    checks++; if (period_cnt !== 8'd20) begin errors++; $display("FAIL half_period: got %0d expected 20", period_cnt); end
    checks++; if (strobe_cnt - base_s !== 3) begin errors++; $display("FAIL half_strobes: got %0d expected 3", strobe_cnt - base_s); end
    checks++; if (long_cnt - base_l !== 0) begin errors++; $display("FAIL half_width: got %0d wide strobes expected 0", long_cnt - base_l); end
  endtask

  task automatic test_stuck_low;
    int base;
    timeout = 8'd40;
    do_reset(1'b0);
    base = strobe_cnt;
    drive(1'b0, 39, 1'b0);
    checks++; if (stuck_l !== 1'b0) begin errors++; $display("FAIL sl_early: got %b expected 0", stuck_l); end
    drive(1'b0, 2, 1'b0);
    checks++; if ({stuck_h, stuck_l} !== 2'b01) begin errors++; $display("FAIL sl_flags: got %b expected 01", {stuck_h, stuck_l}); end
    checks++; if (high_cnt !== 8'd0) begin errors++; $display("FAIL sl_high: got %0d expected 0", high_cnt); end
    checks++; if (period_cnt !== 8'd40) begin errors++; $display("FAIL sl_period: got %0d expected 40", period_cnt); end
    drive(1'b0, 20, 1'b0);
    checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL sl_strobes: got %0d expected 1", strobe_cnt - base); end
    drive(1'b1, 4, 1'b0);
    checks++; if (stuck_l !== 1'b0) begin errors++; $display("FAIL sl_clear: got %b expected 0", stuck_l); end
    checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL sl_clear_strobe: got %0d expected 1", strobe_cnt - base); end
    timeout = '0;
  endtask

  task automatic test_stuck_high;
    int base;
    timeout = 8'd30;
    do_reset(1'b1);
    base = strobe_cnt;
    drive(1'b1, 29, 1'b0);
    checks++; if (stuck_h !== 1'b0) begin errors++; $display("FAIL sh_early: got %b expected 0", stuck_h); end
    drive(1'b1, 2, 1'b0);
    checks++; if ({stuck_h, stuck_l} !== 2'b10) begin errors++; $display("FAIL sh_flags: got %b expected 10", {stuck_h, stuck_l}); end
    checks++; if (high_cnt !== 8'd30) begin errors++; $display("FAIL sh_high: got %0d expected 30", high_cnt); end
    checks++; if (period_cnt !== 8'd30) begin errors++; $display("FAIL sh_period: got %0d expected 30", period_cnt); end
    drive(1'b0, 4, 1'b0);
    checks++; if (stuck_h !== 1'b0) begin errors++; $display("FAIL sh_clear: got %b expected 0", stuck_h); end
    checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL sh_strobes: got %0d expected 1", strobe_cnt - base); end
    timeout = '0;
  endtask

  // Rise lands on the sample where cnt equals the limit: the edge wins.
  task automatic test_edge_vs_timeout;
    int base;
    timeout = 8'd20;
    do_reset(1'b0);
    base = strobe_cnt;
    drive(1'b0, 10, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b0, 15, 1'b0);
    drive(1'b1, 5, 1'b0);
    timeout = '0;
    checks++; if ({stuck_h, stuck_l} !== 2'b00) begin errors++; $display("FAIL evt_flags: got %b expected 00", {stuck_h, stuck_l}); end
    checks++; if (high_cnt !== 8'd5) begin errors++; $display("FAIL evt_high: got %0d expected 5", high_cnt); end
    checks++; if (period_cnt !== 8'd20) begin errors++; $display("FAIL evt_period: got %0d expected 20", period_cnt); end
    checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL evt_strobes: got %0d expected 1", strobe_cnt - base); end
  endtask

  task automatic test_saturate;
    int base;
    timeout = '0;
    do_reset(1'b0);
    base = strobe5_cnt;
    drive(1'b0, 5, 1'b0);
    drive(1'b1, 10, 1'b0);
    drive(1'b0, 30, 1'b0);
    drive(1'b1, 5, 1'b0);
    checks++; if (high5 !== 5'd10) begin errors++; $display("FAIL sat_high: got %0d expected 10", high5); end
    checks++; if (period5 !== 5'd31) begin errors++; $display("FAIL sat_period: got %0d expected 31", period5); end
    checks++; if (strobe5_cnt - base !== 1) begin errors++; $display("FAIL sat_strobes: got %0d expected 1", strobe5_cnt - base); end
    checks++; if (period_cnt !== 8'd40) begin errors++; $display("FAIL wide_period: got %0d expected 40", period_cnt); end
  endtask

  task automatic test_reset_mid;
    int base;
    timeout = '0;
    do_reset(1'b0);
    drive(1'b0, 5, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b0, 15, 1'b0);
    drive(1'b1, 4, 1'b0);
    checks++; if (high_cnt !== 8'd5) begin errors++; $display("FAIL rm_pre_high: got %0d expected 5", high_cnt); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if ({high_cnt, period_cnt} !== 16'd0) begin errors++; $display("FAIL rm_async: got %0d/%0d expected 0/0", high_cnt, period_cnt); end
    step(1);
    rstn = 1'b1;
    base = strobe_cnt;
    drive(1'b1, 3, 1'b0);
    drive(1'b0, 15, 1'b0);
    drive(1'b1, 5, 1'b0);
    checks++; if (strobe_cnt - base !== 0) begin errors++; $display("FAIL rm_first_rise: got %0d strobes expected 0", strobe_cnt - base); end
    drive(1'b0, 15, 1'b0);
    drive(1'b1, 5, 1'b0);
    checks++; if (strobe_cnt - base !== 1) begin errors++; $display("FAIL rm_second_rise: got %0d strobes expected 1", strobe_cnt - base); end
    checks++; if (period_cnt !== 8'd20) begin errors++; $display("FAIL rm_period: got %0d expected 20", period_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_half_rate;
    test_stuck_low;
    test_stuck_high;
    test_edge_vs_timeout;
    test_saturate;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_BITWIDTH, default 8: width of the sample counter and of all count outputs.
REQ-002 Parameter SYNC_STAGES, default 2: number of input synchronizer flops, minimum 2.
REQ-003 clk_i  input  1  system clock; one clock, rising-edge only.
REQ-004 rstn_i  input  1  reset; asynchronous, active-low.
REQ-005 clk_en_i  input  1  sample enable; all state advances only on clk_i edges where clk_en_i=1, except REQ-019.
REQ-006 PWM_pin_i  input  1  asynchronous PWM waveform from the fan controller output.
REQ-007 timeout_i  input  CNT_BITWIDTH  stuck-detect limit in enabled samples; 0 disables timeout.
REQ-008 high_cnt_o  output  CNT_BITWIDTH  measured high time in enabled samples.
REQ-009 period_cnt_o  output  CNT_BITWIDTH  measured period in enabled samples.
REQ-010 valid_STRB_o  output  1  one-clk_i-cycle pulse when high_cnt_o/period_cnt_o update.
REQ-011 stuck_high_o  output  1  pin held high for timeout_i samples.
REQ-012 stuck_low_o  output  1  pin held low (or never toggled) for timeout_i samples.

Function
REQ-013 PWM_pin_i SHALL pass through a SYNC_STAGES-flop synchronizer plus one history flop (prev); rise = sync_out & ~prev, fall = ~sync_out & prev.
REQ-014 The FSM SHALL have states IDLE, HIGH, LOW, STUCK; reset state IDLE.
REQ-015 A counter cnt SHALL load 1 on every enabled rise, otherwise increment per enabled sample, saturating at 2^CNT_BITWIDTH-1 (no wrap).
REQ-016 IDLE: rise -> HIGH, no publish; fall ignored.
REQ-017 HIGH: fall -> latch high_reg <= cnt, go LOW; rise cannot occur.
REQ-018 LOW: rise -> publish high_cnt_o <= high_reg, period_cnt_o <= cnt, go HIGH.
REQ-019 valid_STRB_o SHALL be high for exactly one clk_i cycle after each publish, regardless of clk_en_i in the following cycle.
REQ-020 Waveform high H samples, low L samples SHALL publish high_cnt_o=H, period_cnt_o=H+L (both saturating).
REQ-021 Latency: a rise captured by the first sync flop at enabled sample k SHALL yield valid_STRB_o high in the clk_i cycle after enabled sample k+SYNC_STAGES.
REQ-022 Timeout (timeout_i != 0, cnt == timeout_i, no edge that sample): from HIGH, or IDLE with sync_out=1 -> publish high=period=timeout_i, stuck_high_o=1, go STUCK; from LOW, or IDLE with sync_out=0 -> publish high=0, period=timeout_i, stuck_low_o=1, go STUCK.
REQ-023 Edge and timeout in the same sample: edge SHALL win; no timeout publish.
REQ-024 STUCK: rise -> clear both stuck flags, cnt=1, go HIGH, no publish; fall -> clear stuck_high_o, go IDLE; no further timeout publishes while in STUCK.
REQ-025 timeout_i changes SHALL take effect on the next enabled sample; timeout_i lowered below current cnt SHALL NOT fire until cnt saturates... (it never fires; equality compare only).
REQ-026 stuck_high_o and stuck_low_o SHALL never be high simultaneously.

Reset
REQ-027 rstn_i low SHALL immediately force: state IDLE, cnt=0, high_reg=0, all outputs 0.
REQ-028 Synchronizer flops and prev SHALL reset to 1, so a pin high at reset release produces no rise and a pin low produces an ignored fall.
REQ-029 Reset asserted mid-measurement SHALL discard the partial measurement; first publish after release follows the second rise.

Verification
REQ-030 clk_en_i=1, timeout_i=0, PWM H=5/L=15 repeating -> from second rise on, high_cnt_o=5, period_cnt_o=20, valid_STRB_o one cycle per period.
REQ-031 clk_en_i high every other clk_i, same waveform in enabled samples -> identical counts; strobe width one clk_i cycle.
REQ-032 Pin low from reset, timeout_i=40 -> after 40 enabled samples stuck_low_o=1, high=0, period=40, one strobe; later rise clears stuck_low_o without strobe.
REQ-033 Pin high at reset, timeout_i=30 -> no HIGH entry, stuck_high_o=1, high=period=30 at sample 30.
REQ-034 CNT_BITWIDTH=5, H=10/L=30, timeout_i=0 -> high_cnt_o=10, period_cnt_o=31 (saturated).
REQ-035 rstn_i pulsed low mid-HIGH -> outputs 0 asynchronously; no strobe until second rise after release.
